// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx : I2S serial-to-parallel receiver (bit-clock slave)
//
// Samples ws / sdata on the rising edge of i_sclk and deserializes MSB-first
// channel words. One left/right pair is presented per stereo frame, together
// with a single-cycle o_valid strobe on the posedge that samples ws 1->0.
//
// Optional feature:
//   I2SRX_FRAME_CHECK_EN  - when defined, builds the slot-length checker that
//                           drives the sticky o_frame_err flag. When left
//                           undefined, no check logic exists and o_frame_err
//                           is tied low.
//
// WIDTH must lie in 1..63 because the per-slot sample counter is 6 bits wide
// and saturates at 63.
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             i_sclk,
    input  logic             i_rst,
    input  logic             i_ws,
    input  logic             i_sdata,
    output logic [WIDTH-1:0] o_left_chan,
    output logic [WIDTH-1:0] o_right_chan,
    output logic             o_valid,
    output logic             o_frame_err
);

    // Receiver states: SYNC waits for the first ws edge, RUN captures slots.
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter ceiling and the index of the last captured sample in a slot.
    localparam logic [5:0]       CNT_MAX  = 6'd63;
    localparam logic [5:0]       LAST_IDX = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    logic [0:0]       r_state;
    logic             r_ws_q;
    logic [5:0]       r_bit_cnt;
    logic [WIDTH-1:0] r_slot;
    logic [WIDTH-1:0] r_left_hold;
    logic             r_left_ok;
    logic [WIDTH-1:0] r_left_chan;
    logic [WIDTH-1:0] r_right_chan;
    logic             r_valid;

    logic             w_edge;
    logic             w_in_range;
    logic [5:0]       w_bit_pos;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_slot_word;

    // Slot boundary: ws differs from its previous sample.
    always_comb begin
        w_edge = (i_ws != r_ws_q);
    end

    // Slot word including the sample taken this cycle; samples beyond WIDTH
    // are dropped so long slots truncate to their MSB-aligned top bits.
    always_comb begin
        w_in_range  = (r_bit_cnt <= LAST_IDX);
        w_bit_pos   = LAST_IDX - r_bit_cnt;
        w_bit_mask  = ONE_W << w_bit_pos;
        if (w_in_range && i_sdata) begin
            w_slot_word = r_slot | w_bit_mask;
        end else begin
            w_slot_word = r_slot;
        end
    end

    // Main receive state machine: bit capture, left holding, pair delivery.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state      <= ST_SYNC;
            r_ws_q       <= 1'b0;
            r_bit_cnt    <= 6'd0;
            r_slot       <= ZERO_W;
            r_left_hold  <= ZERO_W;
            r_left_ok    <= 1'b0;
            r_left_chan  <= ZERO_W;
            r_right_chan <= ZERO_W;
            r_valid      <= 1'b0;
        end else begin
            r_ws_q  <= i_ws;
            r_valid <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    // Data is discarded until the first edge aligns us.
                    if (w_edge) begin
                        r_state   <= ST_RUN;
                        r_bit_cnt <= 6'd0;
                        r_slot    <= ZERO_W;
                        r_left_ok <= 1'b0;
                    end else begin
                        r_state   <= ST_SYNC;
                        r_bit_cnt <= 6'd0;
                        r_slot    <= ZERO_W;
                    end
                end
                ST_RUN: begin
                    if (w_edge) begin
                        // Every boundary restarts capture for the next slot.
                        r_bit_cnt <= 6'd0;
                        r_slot    <= ZERO_W;
                        if (!r_ws_q) begin
                            // Left slot just ended: park it until its right partner.
                            r_left_hold <= w_slot_word;
                            r_left_ok   <= 1'b1;
                        end else begin
                            // Right slot just ended: deliver only a complete pair.
                            if (r_left_ok) begin
                                r_left_chan  <= r_left_hold;
                                r_right_chan <= w_slot_word;
                                r_valid      <= 1'b1;
                            end else begin
                                r_left_chan  <= r_left_chan;
                                r_right_chan <= r_right_chan;
                            end
                            r_left_ok <= 1'b0;
                        end
                    end else begin
                        r_slot <= w_slot_word;
                        if (r_bit_cnt != CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_SYNC;
                    r_bit_cnt <= 6'd0;
                    r_slot    <= ZERO_W;
                    r_left_ok <= 1'b0;
                end
            endcase
        end
    end

    assign o_left_chan  = r_left_chan;
    assign o_right_chan = r_right_chan;
    assign o_valid      = r_valid;

`ifdef I2SRX_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_slot_bad;

    // A slot is bad when it is shorter than WIDTH or overran the counter.
    always_comb begin
        w_slot_bad = (r_bit_cnt < LAST_IDX) || (r_bit_cnt == CNT_MAX);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
        end else if ((r_state == ST_RUN) && w_edge && w_slot_bad) begin
            r_frame_err <= 1'b1;
        end else begin
            r_frame_err <= r_frame_err;
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign o_frame_err = 1'b0;
`endif

endmodule
